scr1_dmem_tcm_responder: RTL and testbench

- Target-side endpoint for the high-speed DMEM protocol; sits on the router's port0 side.
- Accepts req/cmd/width/addr/wdata, performs the access on an internal LSU-line-wide tightly-coupled memory and returns resp/rdata.
- Supports back-to-back pipelined requests at LATENCY=1 and configurable wait states, so the initiator's pipelined and stalled paths can both be exercised.

---
 rtl/scr1_dmem_tcm_responder.sv | 143 ++++++++++++++
 tb/tb_scr1_dmem_tcm_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_dmem_tcm_responder.sv
// DMEM-protocol target backed by a line-wide tightly-coupled memory.
// Valid/ready: a request transfers on a rising edge where req and req_ack are both high.
module scr1_dmem_tcm_responder #(
  parameter int                LSU_WIDTH = 128,
  parameter int                AWIDTH    = 32,
  parameter int                DEPTH     = 256,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0001_0000,
  parameter int                LATENCY   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 req_ack,
  input  logic                 req,
  input  logic                 cmd,
  input  logic [1:0]           width,
  input  logic [AWIDTH-1:0]    addr,
  input  logic [LSU_WIDTH-1:0] wdata,
  output logic [LSU_WIDTH-1:0] rdata,
  output logic [1:0]           resp
);

  localparam int NBYTES = LSU_WIDTH / 8;
  localparam int OFFW   = $clog2(NBYTES);
  localparam int IDXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH:0] MEM_BYTES = (AWIDTH + 1)'(DEPTH * NBYTES);
  localparam logic [1:0] CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] RESP_NOTRDY = 2'd0;
  localparam logic [1:0] RESP_OK     = 2'd1;
  localparam logic [1:0] RESP_ER     = 2'd2;

  logic [LSU_WIDTH-1:0] mem [DEPTH];

  logic [1:0]           state;
  logic [1:0]           cnt;
  logic                 cmd_q;
  logic                 err_q;
  logic [IDXW-1:0]      idx_q;
  logic [NBYTES-1:0]    be_q;
  logic [LSU_WIDTH-1:0] wdata_q;
  logic [LSU_WIDTH-1:0] rdata_q;

  logic [AWIDTH-1:0]    in_off;
  logic [OFFW-1:0]      in_mask;
  logic                 in_err;
  logic [IDXW-1:0]      in_idx;
  logic [NBYTES-1:0]    in_be;

  // in_mask holds the low address bits that must be zero for the access size.
  always_comb begin
    in_off = addr - BASE_ADDR;
    case (width)
      2'd0:    in_mask = '0;
      2'd1:    in_mask = OFFW'(1);
      2'd2:    in_mask = OFFW'(3);
      default: in_mask = '1;
    endcase
    in_err = ((addr[OFFW-1:0] & in_mask) != '0) || (addr < BASE_ADDR) ||
             ({1'b0, in_off} >= MEM_BYTES);
    in_idx = in_off[OFFW +: IDXW];
    for (int k = 0; k < NBYTES; k++)
      in_be[k] = ((OFFW'(k) & ~in_mask) == (addr[OFFW-1:0] & ~in_mask));
  end

  logic                 accept;
  logic                 commit;
  logic                 sample;
  logic                 rd_ok;
  logic [IDXW-1:0]      rd_idx;
  logic [LSU_WIDTH-1:0] rd_line;

  assign req_ack = (state == ST_IDLE) || ((LATENCY == 1) && (state == ST_RESP));
  assign accept  = req && req_ack;
  assign commit  = (state == ST_RESP) && cmd_q && !err_q;
  assign resp    = (state != ST_RESP) ? RESP_NOTRDY : (err_q ? RESP_ER : RESP_OK);
  assign rdata   = rdata_q;

  // A read sampled on the edge that commits a pending write sees the merged line.
  always_comb begin
    if (LATENCY == 1) begin
      sample = accept;
      rd_idx = in_idx;
      rd_ok  = !cmd && !in_err;
    end else begin
      sample = (state == ST_WAIT) && (cnt == 2'd0);
      rd_idx = idx_q;
      rd_ok  = !cmd_q && !err_q;
    end
    rd_line = mem[rd_idx];
    for (int k = 0; k < NBYTES; k++)
      if (commit && (idx_q == rd_idx) && be_q[k])
        rd_line[8*k +: 8] = wdata_q[8*k +: 8];
  end

  always_ff @(posedge clk) begin
    if (commit)
      for (int k = 0; k < NBYTES; k++)
        if (be_q[k]) mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 2'd0;
      cmd_q   <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        cmd_q   <= cmd;
        err_q   <= in_err;
        idx_q   <= in_idx;
        be_q    <= in_be;
        wdata_q <= wdata;
      end
      if (sample) rdata_q <= rd_ok ? rd_line : '0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 2'd0) state <= ST_RESP;
          else             cnt   <= cnt - 2'd1;
        end
        ST_RESP: state <= accept ? ST_RESP : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst) req |-> !$isunknown({cmd, width, addr}));

endmodule

// File: tb/tb_scr1_dmem_tcm_responder.sv
// Bench for scr1_dmem_tcm_responder: one LATENCY=1 and one LATENCY=3 instance
// checked against a byte-array memory model with in-order response expectations.
module tb_scr1_dmem_tcm_responder;

  localparam int W         = 128;
  localparam int AW        = 32;
  localparam int NB        = W / 8;
  localparam int DEPTH     = 256;
  localparam int MEM_BYTES = DEPTH * NB;
  localparam int EXP_W     = W + 3;
  localparam logic [AW-1:0] BASE = 32'h0001_0000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         rst_v;
  logic [1:0]         req_v;
  logic [1:0]         cmd_v;
  logic [1:0][1:0]    width_v;
  logic [1:0][AW-1:0] addr_v;
  logic [1:0][W-1:0]  wdata_v;
  wire  [1:0]         ack_v;
  wire  [1:0][1:0]    resp_v;
  wire  [1:0][W-1:0]  rdata_v;

  scr1_dmem_tcm_responder #(.LSU_WIDTH(W), .AWIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst_v[0]), .req_ack(ack_v[0]), .req(req_v[0]), .cmd(cmd_v[0]),
    .width(width_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]), .rdata(rdata_v[0]), .resp(resp_v[0]));

  scr1_dmem_tcm_responder #(.LSU_WIDTH(W), .AWIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst_v[1]), .req_ack(ack_v[1]), .req(req_v[1]), .cmd(cmd_v[1]),
    .width(width_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]), .rdata(rdata_v[1]), .resp(resp_v[1]));

  // scoreboard state
  logic [7:0]       mdl [2][MEM_BYTES];
  logic [EXP_W-1:0] exp_q[$];
  int               due_q[$];
  int               cyc;
  int               next_free [2];
  int               total;
  int               bad;

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [W-1:0] pat(int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  function automatic logic [W-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Memory semantics in program order: errors touch nothing, reads return the whole line.
  task automatic model(int d, bit c, logic [1:0] w, logic [AW-1:0] a, logic [W-1:0] wd,
                       output bit err, output logic [W-1:0] line);
    int size;
    int off;
    int lb;
    size = (w == 2'd3) ? NB : (1 << w);
    off  = int'(a) - int'(BASE);
    err  = (int'(a) % size != 0) || (off < 0) || (off >= MEM_BYTES);
    line = '0;
    if (!err) begin
      lb = off - (off % NB);
      if (c) begin
        for (int k = 0; k < size; k++) mdl[d][off + k] = wd[8 * ((off + k) % NB) +: 8];
      end else begin
        for (int k = 0; k < NB; k++) line[8*k +: 8] = mdl[d][lb + k];
      end
    end
  endtask

  // driver: one cycle of stimulus, checks at the falling edge
  task automatic step(int d, bit r, bit c, logic [1:0] w, logic [AW-1:0] a, logic [W-1:0] wd,
                      bit use_tab, logic [1:0] t_resp, logic [W-1:0] t_rd, output bit acc);
    bit               exp_ack;
    bit               err;
    logic [W-1:0]     line;
    logic [EXP_W-1:0] e;
    req_v[d] = r; cmd_v[d] = c; width_v[d] = w; addr_v[d] = a; wdata_v[d] = wd;
    @(negedge clk);
    exp_ack = (lat_of(d) == 1) || (cyc >= next_free[d]);
    chk("req_ack", W'(ack_v[d]), W'(exp_ack));
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      chk("resp", W'(resp_v[d]), W'(e[W+1:W]));
      if (e[W+2]) chk("rdata", rdata_v[d], e[W-1:0]);
    end else begin
      chk("resp_notrdy", W'(resp_v[d]), W'(2'd0));
    end
    acc = r && exp_ack;
    if (acc) begin
      model(d, c, w, a, wd, err, line);
      if (use_tab) e = {!c, t_resp, t_rd};
      else         e = {!c, (err ? 2'd2 : 2'd1), line};
      exp_q.push_back(e);
      due_q.push_back(cyc + lat_of(d));
      if (lat_of(d) > 1) next_free[d] = cyc + lat_of(d) + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(int d);
    bit acc;
    step(d, 1'b0, 1'($urandom), 2'($urandom), $urandom, rnd_line(), 1'b0, 2'd0, '0, acc);
  endtask

  task automatic drain(int d);
    for (int i = 0; i < 12 && (due_q.size() > 0 || cyc < next_free[d]); i++) idle(d);
    if (due_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain dut%0d: %0d responses still outstanding, want 0", d, due_q.size());
      exp_q.delete();
      due_q.delete();
    end
  endtask

  task automatic issue(int d, bit c, logic [1:0] w, logic [AW-1:0] a, logic [W-1:0] wd);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) step(d, 1'b1, c, w, a, wd, 1'b0, 2'd0, '0, acc);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    int sel;
    int ln;
    sel = $urandom_range(0, 9);
    ln  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(248, 255);
    if (sel == 0) return BASE - AW'($urandom_range(1, 16));
    if (sel == 1) return BASE + AW'(MEM_BYTES) + AW'($urandom_range(0, 15));
    return BASE + AW'(ln * NB) + AW'($urandom_range(0, NB - 1));
  endfunction

  task automatic rnd_step(int d);
    bit             acc;
    logic [1:0]     w;
    logic [AW-1:0]  a;
    logic [AW-1:0]  mask;
    w    = 2'($urandom);
    a    = rnd_addr();
    mask = (w == 2'd3) ? AW'(NB - 1) : AW'((1 << w) - 1);
    if ($urandom_range(0, 1) != 0) a = a & ~mask;
    step(d, ($urandom_range(0, 3) != 0), 1'($urandom), w, a, rnd_line(), 1'b0, 2'd0, '0, acc);
  endtask

  typedef struct {
    bit           cmd;
    logic [1:0]   width;
    logic [AW-1:0] addr;
    logic [W-1:0] wdata;
    logic [1:0]   resp;
    logic [W-1:0] rdata;
  } vec_t;

  localparam logic [W-1:0] L0  = 128'h0123456789ABCDEF_0123456789ABCDEF;
  localparam logic [W-1:0] L0B = 128'h0123456789ABCDEF_0123AB6789ABCDEF;

  initial begin
    vec_t         tab [12];
    bit           acc;
    logic [7:0]   saved [NB];

    tab[0]  = '{1'b1, 2'd3, BASE,                         L0,                     2'd1, 128'h0};
    tab[1]  = '{1'b0, 2'd3, BASE,                         128'h0,                 2'd1, L0};
    tab[2]  = '{1'b1, 2'd0, BASE + 32'd5,                 128'hAB << 40,          2'd1, 128'h0};
    tab[3]  = '{1'b0, 2'd2, BASE + 32'd4,                 128'h0,                 2'd1, L0B};
    tab[4]  = '{1'b1, 2'd1, BASE + 32'd1,                 128'hFFFF << 8,         2'd2, 128'h0};
    tab[5]  = '{1'b0, 2'd2, BASE - 32'd4,                 128'h0,                 2'd2, 128'h0};
    tab[6]  = '{1'b0, 2'd3, BASE,                         128'h0,                 2'd1, L0B};
    tab[7]  = '{1'b1, 2'd2, BASE + 32'(MEM_BYTES) - 32'd4, 128'hDEADBEEF << 96,   2'd1, 128'h0};
    tab[8]  = '{1'b0, 2'd2, BASE + 32'(MEM_BYTES) - 32'd4, 128'h0,                2'd1,
                {32'hDEADBEEF, 32'hC0DE00FF, 32'hC0DE00FF, 32'hC0DE00FF}};
    tab[9]  = '{1'b0, 2'd2, BASE + 32'(MEM_BYTES),        128'h0,                 2'd2, 128'h0};
    tab[10] = '{1'b1, 2'd2, BASE + 32'(MEM_BYTES),        128'hFFFF_FFFF,         2'd2, 128'h0};
    tab[11] = '{1'b0, 2'd0, BASE + 32'h20,                128'h0,                 2'd1, pat(2)};

    total = 0; bad = 0; cyc = 0;
    next_free[0] = 0; next_free[1] = 0;
    rst_v = 2'b11; req_v = '0; cmd_v = '0; width_v = '0; addr_v = '0; wdata_v = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_req_ack", W'(ack_v[d]), W'(1));
      chk("reset_resp", W'(resp_v[d]), W'(0));
      chk("reset_rdata", rdata_v[d], '0);
    end
    @(posedge clk);
    #1;
    rst_v = 2'b00;

    // known contents for the lines the rest of the test touches
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        int ln;
        ln = (i < 8) ? i : 240 + i;
        issue(d, 1'b1, 2'd3, BASE + AW'(ln * NB), pat(ln));
      end
      drain(d);
    end

    // directed vectors at LATENCY=1, issued back to back
    for (int i = 0; i < 12; i++)
      step(0, 1'b1, tab[i].cmd, tab[i].width, tab[i].addr, tab[i].wdata, 1'b1, tab[i].resp, tab[i].rdata, acc);
    drain(0);

    // LATENCY=3: req held high across the wait states
    for (int i = 0; i < 6; i++)
      step(1, 1'b1, 1'b0, 2'd2, BASE + AW'(4 * i), '0, 1'b0, 2'd0, '0, acc);
    drain(1);

    // reset while a LATENCY=3 write waits: it must never reach memory
    for (int k = 0; k < NB; k++) saved[k] = mdl[1][k];
    issue(1, 1'b1, 2'd2, BASE + 32'd8, 128'h55AA55AA << 64);
    rst_v[1] = 1'b1;
    @(negedge clk);
    chk("midrst_resp", W'(resp_v[1]), W'(0));
    chk("midrst_req_ack", W'(ack_v[1]), W'(1));
    chk("midrst_rdata", rdata_v[1], '0);
    @(posedge clk);
    #1;
    cyc++;
    rst_v[1] = 1'b0;
    for (int k = 0; k < NB; k++) mdl[1][k] = saved[k];
    exp_q.delete();
    due_q.delete();
    next_free[1] = cyc;
    issue(1, 1'b0, 2'd3, BASE, '0);
    drain(1);

    // randomized traffic
    for (int n = 0; n < 300; n++) rnd_step(0);
    drain(0);
    for (int n = 0; n < 200; n++) rnd_step(1);
    drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
